rom_port_arbiter: RTL

- Shares the single-port, synchronous-read scancode-to-ASCII ROM between two requesters.
- Port A is the CPU data-memory path. Port B is the keyboard scancode translator.
- Performs the 0x20 region decode (addr[31:24]).
- Sequences the ROM read latency and returns zero-extended data with a one-cycle ack per requester.
- Arbitration is round-robin, so neither port starves.

---
 rtl/rom_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read scancode ROM between the CPU
// data path (port A) and the keyboard translator (port B).
module rom_port_arbiter #(
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned CNT_W       = 4,
  parameter logic [7:0]  REGION      = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_dout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             grant_b_s;
  logic             any_req_s;
  logic [31:0]      sel_addr_s;
  logic             hit_s;
  logic             unused_addr_bits;

  // Pick the port to grant: a lone requester wins, contention goes to the non-owner.
  always_comb begin
    grant_b_s = 1'b0;
    any_req_s = a_req | b_req;
    if (a_req && b_req) begin
      grant_b_s = ~owner;
    end else if (b_req) begin
      grant_b_s = 1'b1;
    end else begin
      grant_b_s = 1'b0;
    end
  end

  assign sel_addr_s = grant_b_s ? b_addr : a_addr;
  assign hit_s      = (sel_addr_s[31:24] == REGION);

  // Byte offset and the middle of the address play no part in the ROM lookup.
  assign unused_addr_bits = ^{a_addr[23:10], a_addr[1:0], b_addr[23:10], b_addr[1:0]};

  // Grant / latency / ack sequencer; every output is driven from a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= 32'h0;
      b_rdata  <= 32'h0;
      rom_addr <= 8'h0;
      busy     <= 1'b0;
      owner    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (any_req_s) begin
            owner <= grant_b_s;
            busy  <= 1'b1;
            if (hit_s) begin
              rom_addr <= sel_addr_s[9:2];
              cnt_r    <= CNT_INIT;
              state_r  <= ST_WAIT;
            end else begin
              // Out-of-region reads complete immediately with zero data.
              if (grant_b_s) begin
                b_rdata <= 32'h0;
                b_ack   <= 1'b1;
              end else begin
                a_rdata <= 32'h0;
                a_ack   <= 1'b1;
              end
              state_r <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            if (owner) begin
              b_rdata <= {24'h0, rom_dout};
              b_ack   <= 1'b1;
            end else begin
              a_rdata <= {24'h0, rom_dout};
              a_ack   <= 1'b1;
            end
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
